// File: rtl/can_mc_bus_arbiter.sv
// Two-requester arbiter for the single MC register port: round-robin grant, one-cycle cs strobe, bounded wait.
// Latency req->done >= 3 cycles (STROBE, WAIT, DONE); requesters hold req until done, extra reqs wait in IDLE.
module can_mc_bus_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_h_req,
  input  logic              i_h_r_neg_w,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_wdata,
  output logic              o_h_done,
  output logic              o_h_error,
  output logic [DATA_W-1:0] o_h_rdata,
  input  logic              i_c_req,
  input  logic              i_c_r_neg_w,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_done,
  output logic              o_c_error,
  output logic [DATA_W-1:0] o_c_rdata,
  output logic              o_cs,
  output logic              o_r_neg_w,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_ack,
  input  logic              i_error,
  output logic              o_busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic              r_neg_w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_c;
  logic              gnt_c;

  cmd_t              h_cmd;
  cmd_t              c_cmd;
  cmd_t              win_cmd;
  logic              pick_c;
  logic              term_resp;
  logic              term_tout;
  logic              res_error;
  logic [DATA_W-1:0] res_rdata;

  // On a tie the requester not granted last wins.
  always_comb begin
    h_cmd     = {i_h_r_neg_w, i_h_addr, i_h_wdata};
    c_cmd     = {i_c_r_neg_w, i_c_addr, i_c_wdata};
    pick_c    = i_c_req && (!i_h_req || !last_c);
    win_cmd   = pick_c ? c_cmd : h_cmd;
    term_resp = i_ack || i_error;
    term_tout = (cnt == CNT_LAST);
    res_error = term_resp ? i_error : 1'b1;
    res_rdata = (term_resp && o_r_neg_w) ? i_reg_data : '0;
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_c     <= 1'b1;
      gnt_c      <= 1'b0;
      o_cs       <= 1'b0;
      o_r_neg_w  <= 1'b0;
      o_addr     <= '0;
      o_bus_data <= '0;
      o_busy     <= 1'b0;
      o_h_done   <= 1'b0;
      o_h_error  <= 1'b0;
      o_h_rdata  <= '0;
      o_c_done   <= 1'b0;
      o_c_error  <= 1'b0;
      o_c_rdata  <= '0;
    end else begin
      o_cs     <= 1'b0;
      o_h_done <= 1'b0;
      o_c_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_h_req || i_c_req) begin
            o_r_neg_w  <= win_cmd.r_neg_w;
            o_addr     <= win_cmd.addr;
            o_bus_data <= win_cmd.wdata;
            gnt_c      <= pick_c;
            last_c     <= pick_c;
            o_cs       <= 1'b1;
            o_busy     <= 1'b1;
            state      <= S_STROBE;
          end
        end
        S_STROBE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the final timeout cycle still counts as a real response.
          if (term_resp || term_tout) begin
            if (gnt_c) begin
              o_c_done  <= 1'b1;
              o_c_error <= res_error;
              o_c_rdata <= res_rdata;
            end else begin
              o_h_done  <= 1'b1;
              o_h_error <= res_error;
              o_h_rdata <= res_rdata;
            end
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
